// File: rtl/des_stream_ctrl_pkg.sv
// Shared constants for the DES stream wrapper: state encoding, widths and
// reference test-vector values used by benches.
package des_pkg;

  localparam int BLOCK_W = 64;
  localparam int BYTE_W  = 8;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    S_FILL = ST_FILL,
    S_RUN  = ST_RUN,
    S_OUT  = ST_OUT
  } state_e;

  // Classic single-block DES known-answer vector
  localparam logic [63:0] TV_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] TV_PT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TV_CT  = 64'h85E8_1354_0F0A_B405;

endpackage

// File: rtl/des_stream_ctrl_if.sv
// Byte-in / block-out stream bundle between the system bus and the DES wrapper.
interface des_stream_ctrl_if;
  import des_pkg::*;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic [BLOCK_W-1:0] out_data;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_stream_ctrl_packer.sv
// Collects eight bytes into one 64-bit block; the first byte lands in the
// most-significant lane (DES bits 1..8).
module des_byte_packer
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               block_full
);

  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               accept;

  assign in_ready   = en;
  assign accept     = in_valid && en;
  assign block_full = accept && (byte_cnt_q == 3'd7);
  assign block      = block_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    block_d    = block_q;
    if (accept) begin
      // 3-bit counter wraps to 0 after the eighth byte
      block_d[BLOCK_W-1-BYTE_W*int'(byte_cnt_q) -: BYTE_W] = in_data;
      byte_cnt_d = byte_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      block_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      block_q    <= block_d;
    end
  end

endmodule

// File: rtl/des_stream_ctrl.sv
// DES core wrapper: byte packing, key hold, start/ready sequencing and a
// watchdog. Optional CBC chaining is enabled with DES_CBC_EN.
module des_stream_ctrl
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               rst,
  des_stream_ctrl_if.slave   s,
  input  logic               key_load,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               key_ready,
`ifdef DES_CBC_EN
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv_in,
`endif
  output logic               des_start,
  output logic [BLOCK_W-1:0] des_in,
  output logic [BLOCK_W-1:0] des_key,
  input  logic               des_ready,
  input  logic [BLOCK_W-1:0] des_out,
  output logic               err_timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic               err_q, err_d;
  logic [BLOCK_W-1:0] block;
  logic               block_full;

  des_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == S_FILL),
    .in_valid   (s.in_valid),
    .in_data    (s.in_data),
    .in_ready   (s.in_ready),
    .block      (block),
    .block_full (block_full)
  );

  assign des_start   = (state_q == S_RUN);
  assign s.out_valid = (state_q == S_OUT);
  assign s.out_data  = out_data_q;
  assign key_ready   = (state_q != S_RUN);
  assign des_key     = key_q;
  assign err_timeout = err_q;

`ifdef DES_CBC_EN
  logic [BLOCK_W-1:0] chain_q, chain_d;
  assign des_in = block ^ chain_q;
`else
  assign des_in = block;
`endif

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    key_d      = key_q;
    out_data_d = out_data_q;
    err_d      = err_q;
`ifdef DES_CBC_EN
    chain_d    = chain_q;
`endif
    case (state_q)
      S_FILL: begin
        if (block_full) begin
          state_d = S_RUN;
          wdog_d  = '0;
        end
      end
      S_RUN: begin
        // A completion in the final watchdog cycle still counts as success
        if (des_ready) begin
          out_data_d = des_out;
          state_d    = S_OUT;
          wdog_d     = '0;
`ifdef DES_CBC_EN
          chain_d    = des_out;
`endif
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_FILL;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_OUT: begin
        if (s.out_ready) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
    if (key_load && key_ready) begin
      key_d = key_in;
      err_d = 1'b0;
    end
`ifdef DES_CBC_EN
    if (iv_load && key_ready) begin
      chain_d = iv_in;
      err_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      wdog_q     <= '0;
      key_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
`ifdef DES_CBC_EN
      chain_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      key_q      <= key_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
`ifdef DES_CBC_EN
      chain_q    <= chain_d;
`endif
    end
  end

endmodule
